axis_dest_demux: RTL and testbench

Single-input, M_COUNT-output AXI4-Stream packet demultiplexer, routed by tdest. It is the fan-out counterpart of the arbitrated mux in the stream library. The port index is read from the top bits of tdest on the first beat of each packet and held until tlast. Those bits are then stripped from the forwarded tdest, undoing the mux's tid/tdest index insertion. A registered skid buffer on the output gives full throughput, with s_axis_tready driven from a register.

---
 rtl/axis_dest_demux_pkg.sv | 9 +
 rtl/axis_dest_demux_skid.sv | 79 +++++++
 rtl/axis_dest_demux.sv | 130 +++++++++++++
 tb/tb_axis_dest_demux.sv | 297 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axis_dest_demux_pkg.sv
// Shared types for the tdest-routed AXI4-Stream demultiplexer.
package axis_dest_demux_pkg;

   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_FRAME = 1'b1
   } state_e;

endpackage

// File: rtl/axis_dest_demux_skid.sv
// Output register plus temp register (skid buffer) carrying a payload and a port index.
module axis_skid_reg #(
   parameter int PW = 8,
   parameter int SW = 2
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          in_valid_i,
   input  logic [PW-1:0] in_data_i,
   input  logic [SW-1:0] in_sel_i,
   output logic          in_ready_o,
   output logic          out_valid_o,
   output logic [PW-1:0] out_data_o,
   output logic [SW-1:0] out_sel_o,
   input  logic          out_ready_i
);

   logic          ready_q, ready_d;
   logic          valid_q, valid_d;
   logic          temp_valid_q, temp_valid_d;
   logic [PW-1:0] data_q, temp_data_q;
   logic [SW-1:0] sel_q, temp_sel_q;
   logic          store_out, store_temp, temp_to_out;

   always_comb begin
      valid_d      = valid_q;
      temp_valid_d = temp_valid_q;
      store_out    = 1'b0;
      store_temp   = 1'b0;
      temp_to_out  = 1'b0;
      ready_d      = !temp_valid_q && (!valid_q || out_ready_i);
      if (ready_q) begin
         if (out_ready_i || !valid_q) begin
            valid_d   = in_valid_i;
            store_out = 1'b1;
         end else begin
            temp_valid_d = in_valid_i;
            store_temp   = 1'b1;
         end
      end else if (out_ready_i) begin
         valid_d      = temp_valid_q;
         temp_valid_d = 1'b0;
         temp_to_out  = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         ready_q      <= 1'b0;
         valid_q      <= 1'b0;
         temp_valid_q <= 1'b0;
         data_q       <= '0;
         sel_q        <= '0;
         temp_data_q  <= '0;
         temp_sel_q   <= '0;
      end else begin
         ready_q      <= ready_d;
         valid_q      <= valid_d;
         temp_valid_q <= temp_valid_d;
         if (store_out) begin
            data_q <= in_data_i;
            sel_q  <= in_sel_i;
         end else if (temp_to_out) begin
            data_q <= temp_data_q;
            sel_q  <= temp_sel_q;
         end
         if (store_temp) begin
            temp_data_q <= in_data_i;
            temp_sel_q  <= in_sel_i;
         end
      end
   end

   assign in_ready_o  = ready_q;
   assign out_valid_o = valid_q;
   assign out_data_o  = data_q;
   assign out_sel_o   = sel_q;

endmodule

// File: rtl/axis_dest_demux.sv
// AXI4-Stream demux: routes each packet by the top bits of tdest, strips them, and
// forwards through a registered skid stage shared by all output ports.
module axis_dest_demux
   import axis_dest_demux_pkg::*;
#(
   parameter int M_COUNT      = 4,
   parameter int DATA_WIDTH   = 8,
   parameter int KEEP_ENABLE  = (DATA_WIDTH > 8),
   parameter int KEEP_WIDTH   = (DATA_WIDTH + 7) / 8,
   parameter int ID_ENABLE    = 0,
   parameter int ID_WIDTH     = 8,
   parameter int S_DEST_WIDTH = 8,
   parameter int M_DEST_WIDTH = S_DEST_WIDTH - $clog2(M_COUNT),
   parameter int USER_ENABLE  = 1,
   parameter int USER_WIDTH   = 1,
   parameter int LAST_ENABLE  = 1,
   localparam int CL_M_COUNT       = $clog2(M_COUNT),
   localparam int M_DEST_WIDTH_INT = (M_DEST_WIDTH > 0) ? M_DEST_WIDTH : 1
) (
   input  logic                               clk,
   input  logic                               rst,
   input  logic                               enable,
   input  logic                               drop,
   input  logic [DATA_WIDTH-1:0]              s_axis_tdata,
   input  logic [KEEP_WIDTH-1:0]              s_axis_tkeep,
   input  logic                               s_axis_tvalid,
   output logic                               s_axis_tready,
   input  logic                               s_axis_tlast,
   input  logic [ID_WIDTH-1:0]                s_axis_tid,
   input  logic [S_DEST_WIDTH-1:0]            s_axis_tdest,
   input  logic [USER_WIDTH-1:0]              s_axis_tuser,
   output logic [M_COUNT*DATA_WIDTH-1:0]      m_axis_tdata,
   output logic [M_COUNT*KEEP_WIDTH-1:0]      m_axis_tkeep,
   output logic [M_COUNT-1:0]                 m_axis_tvalid,
   input  logic [M_COUNT-1:0]                 m_axis_tready,
   output logic [M_COUNT-1:0]                 m_axis_tlast,
   output logic [M_COUNT*ID_WIDTH-1:0]        m_axis_tid,
   output logic [M_COUNT*M_DEST_WIDTH_INT-1:0] m_axis_tdest,
   output logic [M_COUNT*USER_WIDTH-1:0]      m_axis_tuser
);

   if (M_COUNT < 2) begin : g_bad_count
      $error("axis_dest_demux: M_COUNT must be at least 2");
   end
   if (S_DEST_WIDTH < CL_M_COUNT) begin : g_bad_dest
      $error("axis_dest_demux: S_DEST_WIDTH too small for M_COUNT");
   end

   localparam int PW = DATA_WIDTH + KEEP_WIDTH + 1 + ID_WIDTH + M_DEST_WIDTH_INT + USER_WIDTH;

   state_e                  state_q;
   logic [CL_M_COUNT-1:0]   select_q, sel_in, cur_sel, out_sel;
   logic                    drop_q, drop_in, cur_drop, frame;
   logic                    ready_int, s_xfer, beat_valid;
   logic                    out_valid, out_ready, last_in;
   logic [M_COUNT-1:0]      m_valid;
   logic [PW-1:0]           in_pld, out_pld;
   logic [DATA_WIDTH-1:0]   o_data;
   logic [KEEP_WIDTH-1:0]   o_keep, keep_eff;
   logic                    o_last;
   logic [ID_WIDTH-1:0]     o_id, id_eff;
   logic [M_DEST_WIDTH_INT-1:0] o_dest;
   logic [USER_WIDTH-1:0]   o_user, user_eff;

   assign sel_in   = s_axis_tdest[S_DEST_WIDTH-1 -: CL_M_COUNT];
   assign drop_in  = drop || ({1'b0, sel_in} >= (CL_M_COUNT+1)'(M_COUNT));
   assign frame    = (state_q == ST_FRAME);
   // First beat is steered by the live tdest/drop; the registered copies cover the rest.
   assign cur_sel  = frame ? select_q : sel_in;
   assign cur_drop = frame ? drop_q : drop_in;

   assign s_axis_tready = ready_int && (frame || enable);
   assign s_xfer        = s_axis_tvalid && s_axis_tready;
   assign beat_valid    = s_xfer && !cur_drop;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= ST_IDLE;
         select_q <= '0;
         drop_q   <= 1'b0;
      end else if (s_xfer) begin
         if (state_q == ST_IDLE) begin
            select_q <= sel_in;
            drop_q   <= drop_in;
            if ((LAST_ENABLE != 0) && !s_axis_tlast) state_q <= ST_FRAME;
         end else if (s_axis_tlast) begin
            state_q <= ST_IDLE;
         end
      end
   end

   // Without tlast tracking every beat is its own packet, so it leaves marked last.
   assign last_in = (LAST_ENABLE != 0) ? s_axis_tlast : 1'b1;
   assign in_pld  = {s_axis_tdata, s_axis_tkeep, last_in, s_axis_tid,
                     s_axis_tdest[M_DEST_WIDTH_INT-1:0], s_axis_tuser};

   axis_skid_reg #(
      .PW(PW),
      .SW(CL_M_COUNT)
   ) u_skid (
      .clk         (clk),
      .rst         (rst),
      .in_valid_i  (beat_valid),
      .in_data_i   (in_pld),
      .in_sel_i    (cur_sel),
      .in_ready_o  (ready_int),
      .out_valid_o (out_valid),
      .out_data_o  (out_pld),
      .out_sel_o   (out_sel),
      .out_ready_i (out_ready)
   );

   assign {o_data, o_keep, o_last, o_id, o_dest, o_user} = out_pld;

   assign m_valid   = M_COUNT'(out_valid) << out_sel;
   assign out_ready = |(m_axis_tready & m_valid);

   assign keep_eff = (KEEP_ENABLE != 0) ? o_keep : {KEEP_WIDTH{1'b1}};
   assign id_eff   = (ID_ENABLE != 0)   ? o_id   : {ID_WIDTH{1'b0}};
   assign user_eff = (USER_ENABLE != 0) ? o_user : {USER_WIDTH{1'b0}};

   assign m_axis_tvalid = m_valid;
   assign m_axis_tdata  = {M_COUNT{o_data}};
   assign m_axis_tkeep  = {M_COUNT{keep_eff}};
   assign m_axis_tlast  = {M_COUNT{o_last}};
   assign m_axis_tid    = {M_COUNT{id_eff}};
   assign m_axis_tdest  = {M_COUNT{o_dest}};
   assign m_axis_tuser  = {M_COUNT{user_eff}};

endmodule

// File: tb/tb_axis_dest_demux.sv
// Scoreboard bench for axis_dest_demux: three instances (M_COUNT=4, M_COUNT=3, LAST_ENABLE=0).
module tb_axis_dest_demux;

   typedef struct packed {
      logic [1:0] inst;
      logic [1:0] port;
      logic [7:0] data;
      logic [5:0] dest;
      logic       last;
      logic       user;
   } item_t;

   typedef struct packed {
      logic [7:0] d;
      logic [7:0] dest;
      logic       last;
      logic [1:0] port;
      logic [5:0] edest;
      logic       elast;
      logic [3:0] oh;
   } vec_t;

   logic       clk, rst;
   logic [2:0] en, drp, s_tvalid, s_tready, s_tlast, s_tuser;
   logic [7:0] s_tdata [3];
   logic [7:0] s_tdest [3];
   logic [3:0] rdy [3];

   logic [31:0] a_tdata, c_tdata, a_tid, c_tid;
   logic [23:0] b_tdata, b_tid, a_tdest, c_tdest;
   logic [17:0] b_tdest;
   logic [3:0]  a_tkeep, a_tvalid, a_tlast, a_tuser, c_tkeep, c_tvalid, c_tlast, c_tuser;
   logic [2:0]  b_tkeep, b_tvalid, b_tlast, b_tuser;

   logic [31:0] vdata [3];
   logic [23:0] vdest [3];
   logic [3:0]  vvalid [3];
   logic [3:0]  vlast [3];
   logic [3:0]  vuser [3];
   logic [3:0]  vkeep [3];

   item_t expq [$];
   item_t exp_i, got_i;
   int    checks = 0;
   int    errors = 0;
   int    last_wait;
   vec_t  t2 [5];
   vec_t  t6 [4];

   axis_dest_demux #(.M_COUNT(4)) u_a (
      .clk(clk), .rst(rst), .enable(en[0]), .drop(drp[0]),
      .s_axis_tdata(s_tdata[0]), .s_axis_tkeep(1'b1), .s_axis_tvalid(s_tvalid[0]),
      .s_axis_tready(s_tready[0]), .s_axis_tlast(s_tlast[0]), .s_axis_tid(8'h00),
      .s_axis_tdest(s_tdest[0]), .s_axis_tuser(s_tuser[0]),
      .m_axis_tdata(a_tdata), .m_axis_tkeep(a_tkeep), .m_axis_tvalid(a_tvalid),
      .m_axis_tready(rdy[0]), .m_axis_tlast(a_tlast), .m_axis_tid(a_tid),
      .m_axis_tdest(a_tdest), .m_axis_tuser(a_tuser)
   );

   axis_dest_demux #(.M_COUNT(3)) u_b (
      .clk(clk), .rst(rst), .enable(en[1]), .drop(drp[1]),
      .s_axis_tdata(s_tdata[1]), .s_axis_tkeep(1'b1), .s_axis_tvalid(s_tvalid[1]),
      .s_axis_tready(s_tready[1]), .s_axis_tlast(s_tlast[1]), .s_axis_tid(8'h00),
      .s_axis_tdest(s_tdest[1]), .s_axis_tuser(s_tuser[1]),
      .m_axis_tdata(b_tdata), .m_axis_tkeep(b_tkeep), .m_axis_tvalid(b_tvalid),
      .m_axis_tready(rdy[1][2:0]), .m_axis_tlast(b_tlast), .m_axis_tid(b_tid),
      .m_axis_tdest(b_tdest), .m_axis_tuser(b_tuser)
   );

   axis_dest_demux #(.M_COUNT(4), .LAST_ENABLE(0)) u_c (
      .clk(clk), .rst(rst), .enable(en[2]), .drop(drp[2]),
      .s_axis_tdata(s_tdata[2]), .s_axis_tkeep(1'b1), .s_axis_tvalid(s_tvalid[2]),
      .s_axis_tready(s_tready[2]), .s_axis_tlast(s_tlast[2]), .s_axis_tid(8'h00),
      .s_axis_tdest(s_tdest[2]), .s_axis_tuser(s_tuser[2]),
      .m_axis_tdata(c_tdata), .m_axis_tkeep(c_tkeep), .m_axis_tvalid(c_tvalid),
      .m_axis_tready(rdy[2]), .m_axis_tlast(c_tlast), .m_axis_tid(c_tid),
      .m_axis_tdest(c_tdest), .m_axis_tuser(c_tuser)
   );

   assign vdata[0]  = a_tdata;           assign vdata[1]  = {8'h00, b_tdata};  assign vdata[2]  = c_tdata;
   assign vdest[0]  = a_tdest;           assign vdest[1]  = {6'h00, b_tdest};  assign vdest[2]  = c_tdest;
   assign vvalid[0] = a_tvalid;          assign vvalid[1] = {1'b0, b_tvalid};  assign vvalid[2] = c_tvalid;
   assign vlast[0]  = a_tlast;           assign vlast[1]  = {1'b0, b_tlast};   assign vlast[2]  = c_tlast;
   assign vuser[0]  = a_tuser;           assign vuser[1]  = {1'b0, b_tuser};   assign vuser[2]  = c_tuser;
   assign vkeep[0]  = a_tkeep;           assign vkeep[1]  = {1'b0, b_tkeep};   assign vkeep[2]  = c_tkeep;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation still running, expected completion");
      $fatal(1);
   end

   // Monitor: every accepted output beat must match the head of the expected queue.
   always @(negedge clk) begin
      if (!rst) begin
         for (int i = 0; i < 3; i++) begin
            for (int p = 0; p < 4; p++) begin
               if (vvalid[i][p] && rdy[i][p]) begin
                  checks++;
                  got_i.inst = 2'(i);
                  got_i.port = 2'(p);
                  got_i.data = vdata[i][p*8 +: 8];
                  got_i.dest = vdest[i][p*6 +: 6];
                  got_i.last = vlast[i][p];
                  got_i.user = vuser[i][p];
                  if (expq.size() == 0) begin
                     errors++;
                     $display("FAIL unexpected_beat: got inst=%0d port=%0d data=%h, expected no beat",
                              i, p, got_i.data);
                  end else begin
                     exp_i = expq.pop_front();
                     if (got_i !== exp_i) begin
                        errors++;
                        $display("FAIL scoreboard: got inst=%0d port=%0d data=%h dest=%h last=%b user=%b, expected inst=%0d port=%0d data=%h dest=%h last=%b user=%b",
                                 got_i.inst, got_i.port, got_i.data, got_i.dest, got_i.last, got_i.user,
                                 exp_i.inst, exp_i.port, exp_i.data, exp_i.dest, exp_i.last, exp_i.user);
                     end
                  end
               end
            end
         end
      end
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
      checks++;
      if (act !== expv) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", nm, act, expv);
      end
   endtask

   task automatic send(input int inst, input logic [7:0] d, input logic [7:0] dst, input logic lst,
                       input logic usr, input logic dp, input logic exp_on, input logic [1:0] ep,
                       input logic [5:0] ed, input logic el);
      item_t it;
      int    w;
      s_tdata[inst]  = d;
      s_tdest[inst]  = dst;
      s_tlast[inst]  = lst;
      s_tuser[inst]  = usr;
      drp[inst]      = dp;
      s_tvalid[inst] = 1'b1;
      if (exp_on) begin
         it.inst = 2'(inst); it.port = ep; it.data = d; it.dest = ed; it.last = el; it.user = usr;
         expq.push_back(it);
      end
      w = 0;
      forever begin
         @(negedge clk);
         if (s_tready[inst]) break;
         w++;
         if (w >= 50) break;
      end
      last_wait = w;
      checks++;
      if (w >= 50) begin
         errors++;
         $display("FAIL send_timeout: inst %0d got tready=0 for 50 cycles, expected 1", inst);
      end
      @(posedge clk);
      #1;
      s_tvalid[inst] = 1'b0;
      drp[inst]      = 1'b0;
   endtask

   // Full-rate beat: accepted without waiting, and visible on the given one-hot tvalid right after.
   task automatic beat(input int inst, input logic [7:0] d, input logic [7:0] dst, input logic lst,
                       input logic usr, input logic dp, input logic exp_on, input logic [1:0] ep,
                       input logic [5:0] ed, input logic el, input logic [3:0] ev);
      send(inst, d, dst, lst, usr, dp, exp_on, ep, ed, el);
      chk("accept_wait", last_wait, 0);
      chk("tvalid_onehot", vvalid[inst], ev);
   endtask

   task automatic idle(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   initial begin
      t2[0] = '{8'h10, 8'h01, 1'b0, 2'd0, 6'h01, 1'b0, 4'b0001};
      t2[1] = '{8'h11, 8'h01, 1'b1, 2'd0, 6'h01, 1'b1, 4'b0001};
      t2[2] = '{8'h12, 8'hC2, 1'b1, 2'd3, 6'h02, 1'b1, 4'b1000};
      t2[3] = '{8'h13, 8'h47, 1'b0, 2'd1, 6'h07, 1'b0, 4'b0010};
      t2[4] = '{8'h14, 8'h47, 1'b1, 2'd1, 6'h07, 1'b1, 4'b0010};
      t6[0] = '{8'h20, 8'h00, 1'b0, 2'd0, 6'h00, 1'b1, 4'b0001};
      t6[1] = '{8'h21, 8'hC0, 1'b0, 2'd3, 6'h00, 1'b1, 4'b1000};
      t6[2] = '{8'h22, 8'h00, 1'b0, 2'd0, 6'h00, 1'b1, 4'b0001};
      t6[3] = '{8'h23, 8'hC0, 1'b0, 2'd3, 6'h00, 1'b1, 4'b1000};

      rst = 1'b1; en = 3'b111; drp = '0; s_tvalid = '0; s_tlast = '0; s_tuser = '0;
      for (int i = 0; i < 3; i++) begin
         s_tdata[i] = '0; s_tdest[i] = '0; rdy[i] = 4'hF;
      end

      idle(3);
      chk("rst_tready", s_tready, 3'b000);
      chk("rst_tvalid_a", vvalid[0], 4'h0);
      chk("rst_tvalid_b", vvalid[1], 4'h0);
      chk("rst_tdata", vdata[0], 32'h0);
      chk("rst_tkeep", vkeep[0], 4'hF);
      rst = 1'b0;
      chk("tready_low_after_rst", s_tready, 3'b000);
      idle(1);
      chk("tready_rise", s_tready, 3'b111);

      // 3-beat packet to port 2, tdest stripped to 6'h05
      beat(0, 8'h01, 8'h85, 1'b0, 1'b0, 1'b0, 1'b1, 2'd2, 6'h05, 1'b0, 4'b0100);
      beat(0, 8'h02, 8'h85, 1'b0, 1'b0, 1'b0, 1'b1, 2'd2, 6'h05, 1'b0, 4'b0100);
      beat(0, 8'h03, 8'h85, 1'b1, 1'b1, 1'b0, 1'b1, 2'd2, 6'h05, 1'b1, 4'b0100);
      idle(1);
      chk("t1_end_tvalid", vvalid[0], 4'h0);
      idle(2);

      // back-to-back packets to ports 0, 3, 1
      for (int k = 0; k < 5; k++)
         beat(0, t2[k].d, t2[k].dest, t2[k].last, 1'b0, 1'b0, 1'b1, t2[k].port,
              t2[k].edest, t2[k].elast, t2[k].oh);
      idle(3);

      // port 2 stalls mid-packet
      beat(0, 8'h30, 8'h80, 1'b0, 1'b0, 1'b0, 1'b1, 2'd2, 6'h00, 1'b0, 4'b0100);
      rdy[0][2] = 1'b0;
      beat(0, 8'h31, 8'h80, 1'b0, 1'b0, 1'b0, 1'b1, 2'd2, 6'h00, 1'b0, 4'b0100);
      chk("stall_tready_fall", s_tready[0], 0);
      fork
         send(0, 8'h32, 8'h80, 1'b0, 1'b0, 1'b0, 1'b1, 2'd2, 6'h00, 1'b0);
         begin
            repeat (4) begin
               @(negedge clk);
               chk("stall_tready", s_tready[0], 0);
               chk("stall_hold", vvalid[0], 4'b0100);
            end
            @(posedge clk);
            #1;
            rdy[0][2] = 1'b1;
         end
      join
      send(0, 8'h33, 8'h80, 1'b0, 1'b0, 1'b0, 1'b1, 2'd2, 6'h00, 1'b0);
      send(0, 8'h34, 8'h80, 1'b1, 1'b0, 1'b0, 1'b1, 2'd2, 6'h00, 1'b1);
      idle(4);

      // enable low at packet start blocks; low mid-packet does not
      en[0] = 1'b0;
      s_tdata[0] = 8'h40; s_tdest[0] = 8'h40; s_tlast[0] = 1'b0; s_tvalid[0] = 1'b1;
      repeat (3) begin
         @(negedge clk);
         chk("en0_tready", s_tready[0], 0);
      end
      @(posedge clk);
      #1;
      en[0] = 1'b1;
      beat(0, 8'h40, 8'h40, 1'b0, 1'b0, 1'b0, 1'b1, 2'd1, 6'h00, 1'b0, 4'b0010);
      en[0] = 1'b0;
      beat(0, 8'h41, 8'h40, 1'b0, 1'b0, 1'b0, 1'b1, 2'd1, 6'h00, 1'b0, 4'b0010);
      beat(0, 8'h42, 8'h40, 1'b1, 1'b0, 1'b0, 1'b1, 2'd1, 6'h00, 1'b1, 4'b0010);
      chk("en0_after_last", s_tready[0], 0);
      en[0] = 1'b1;
      idle(3);

      // reset mid-packet discards the buffered beat and the open frame
      rdy[0] = 4'b0111;
      beat(0, 8'h50, 8'hC1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd3, 6'h01, 1'b0, 4'b1000);
      rst = 1'b1;
      idle(1);
      chk("rstmid_tvalid", vvalid[0], 4'h0);
      rst = 1'b0;
      rdy[0] = 4'hF;
      send(0, 8'h51, 8'h42, 1'b1, 1'b0, 1'b0, 1'b1, 2'd1, 6'h02, 1'b1);
      chk("rstmid_route", vvalid[0], 4'b0010);
      idle(3);

      // M_COUNT=3: out-of-range index and explicit drop are swallowed
      beat(1, 8'h60, 8'hC0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 6'h00, 1'b0, 4'b0000);
      beat(1, 8'h61, 8'hC0, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 6'h00, 1'b0, 4'b0000);
      beat(1, 8'h62, 8'h40, 1'b0, 1'b0, 1'b1, 1'b0, 2'd0, 6'h00, 1'b0, 4'b0000);
      beat(1, 8'h63, 8'h40, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 6'h00, 1'b0, 4'b0000);
      beat(1, 8'h64, 8'h40, 1'b0, 1'b1, 1'b0, 1'b1, 2'd1, 6'h00, 1'b0, 4'b0010);
      beat(1, 8'h65, 8'h40, 1'b1, 1'b0, 1'b0, 1'b1, 2'd1, 6'h00, 1'b1, 4'b0010);
      idle(3);

      // LAST_ENABLE=0: each beat routed on its own
      for (int k = 0; k < 4; k++)
         beat(2, t6[k].d, t6[k].dest, t6[k].last, 1'b0, 1'b0, 1'b1, t6[k].port,
              t6[k].edest, t6[k].elast, t6[k].oh);
      idle(5);

      chk("drain_queue", expq.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
